// File: rtl/sec_tick_counter_pkg.sv
// -----------------------------------------------------------------------------
// sec_tick_counter_pkg
// Shared definitions for the seconds time-base block and its button path.
//   SEC_W        width of the seconds value
//   SEC_MAX      last seconds value before the wrap to 0
//   run_state_e  run/stop state encoding (STOPPED=0, RUNNING=1)
//   presc_width  prescaler register width for a given clock frequency
// -----------------------------------------------------------------------------
package sec_tick_counter_pkg;

    localparam int SEC_W = 6;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_e;

    // Bits needed to hold 0..clk_hz-1; never less than one bit so that a
    // degenerate CLK_HZ of 1 or 2 still yields a legal register.
    function automatic int presc_width(input int clk_hz);
        return (clk_hz > 2) ? $clog2(clk_hz) : 1;
    endfunction

endpackage

// File: rtl/sec_tick_counter_btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Brings an asynchronous, already debounced button level into the clk domain
// through two synchronizer flops and produces a one-cycle pulse on each
// rising edge of the synchronized level.
//   clk     system clock
//   reset   asynchronous active-high reset, clears all flops to 0
//   btn_in  asynchronous button level
//   rise    one-cycle pulse, high while sync2 is 1 and the delayed copy is 0
// -----------------------------------------------------------------------------
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Decoded from flops only, so the pulse is glitch-free and the consumer
    // acts on it at the very edge that also updates prev_q.
    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/sec_tick_counter.sv
// -----------------------------------------------------------------------------
// sec_tick_counter
// Divides clk down to a 1 Hz tick and counts seconds 0..59, emitting a
// minute carry for the minutes stage. A push button toggles run/stop and a
// one-cycle load strobe presets the seconds value.
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous active-high reset
//   btn_run    asynchronous debounced button; each rising edge toggles run
//   load       one-cycle preset strobe
//   load_val   preset seconds value (values above 59 are ignored)
//   data       registered seconds count 0..59
//   sec_tick   one-cycle pulse in the cycle data first shows an increment
//   min_carry  one-cycle pulse in the cycle data first shows the 59->0 wrap
//   running    1 while in the RUNNING state
// Parameters:
//   CLK_HZ        clk cycles per second
//   RUN_AT_RESET  1: reset enters RUNNING, 0: reset enters STOPPED
// -----------------------------------------------------------------------------
module sec_tick_counter
    import sec_tick_counter_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter bit RUN_AT_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_run,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    output logic [SEC_W-1:0] data,
    output logic             sec_tick,
    output logic             min_carry,
    output logic             running
);

    localparam int             PW          = presc_width(CLK_HZ);
    localparam logic [PW-1:0]  PRESC_TC    = PW'(CLK_HZ - 1);
    localparam run_state_e     RESET_STATE = RUN_AT_RESET ? RUNNING : STOPPED;

    run_state_e       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [SEC_W-1:0] data_q, data_d;
    logic             sec_tick_q, sec_tick_d;
    logic             min_carry_q, min_carry_d;

    logic btn_rise;
    logic tc_hit;
    logic load_ok;

    btn_sync_edge u_btn_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_run),
        .rise   (btn_rise)
    );

    // Terminal count is judged on the current state, so a stop that lands on
    // the terminal-count edge still delivers that second's tick.
    assign tc_hit  = (state_q == RUNNING) && (presc_q == PRESC_TC);
    assign load_ok = load && (load_val <= SEC_MAX);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        data_d      = data_q;
        sec_tick_d  = 1'b0;
        min_carry_d = 1'b0;

        // Run/stop toggle is independent of load; both may act together.
        if (btn_rise) begin
            state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
        end

        if (load_ok) begin
            // A valid preset restarts the second and suppresses any tick due
            // on this edge.
            data_d  = load_val;
            presc_d = '0;
        end else if (state_q == RUNNING) begin
            if (tc_hit) begin
                presc_d    = '0;
                sec_tick_d = 1'b1;
                if (data_q == SEC_MAX) begin
                    data_d      = '0;
                    min_carry_d = 1'b1;
                end else begin
                    data_d = data_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            presc_q     <= '0;
            data_q      <= '0;
            sec_tick_q  <= 1'b0;
            min_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            data_q      <= data_d;
            sec_tick_q  <= sec_tick_d;
            min_carry_q <= min_carry_d;
        end
    end

    assign data      = data_q;
    assign sec_tick  = sec_tick_q;
    assign min_carry = min_carry_q;
    assign running   = (state_q == RUNNING);

endmodule
